// File: rtl/idli_sqi_fetch_m.sv
// -----------------------------------------------------------------------------
// idli_sqi_fetch_m
//
// Instruction fetch front-end. Drives an external quad-SPI (SQI) SRAM that is
// already in sequential SQI mode, issues a single READ (8'h03) per fetch
// target and then streams 16-bit encodings to the execute stage one nibble per
// cycle, indefinitely, until the execute stage redirects the PC.
//
// The free-running 2-bit sync counter frames every word: nibble k of the word
// is presented while o_ex_ctr == k. Redirects are only sampled on the ctr==3
// edge, i.e. on instruction boundaries.
//
// Ports
//   i_ex_gck          core clock, also the SQI memory clock
//   i_ex_rst_n        asynchronous active-low reset
//   o_ex_ctr          sync counter, 0..3 wrapping, never stalls
//   o_ex_enc          current encoding nibble (pass-through of i_mem_sio)
//   o_ex_enc_vld      encoding valid, constant across a word
//   o_ex_pc           word address of the encoding on o_ex_enc
//   i_ex_redirect     redirect request, honoured only at ctr==3
//   i_ex_redirect_pc  redirect target word address
//   o_mem_cs_n        SQI chip select, active-low
//   o_mem_sio         SQI data out
//   o_mem_sio_oe      SQI output enable (1 = drive o_mem_sio)
//   i_mem_sio         SQI data in, valid in the cycle it is sampled
// -----------------------------------------------------------------------------
module idli_sqi_fetch_m #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned CS_IDLE_CYC = 2
) (
  input  logic        i_ex_gck,
  input  logic        i_ex_rst_n,
  output logic [1:0]  o_ex_ctr,
  output logic [3:0]  o_ex_enc,
  output logic        o_ex_enc_vld,
  output logic [15:0] o_ex_pc,
  input  logic        i_ex_redirect,
  input  logic [15:0] i_ex_redirect_pc,
  output logic        o_mem_cs_n,
  output logic [3:0]  o_mem_sio,
  output logic        o_mem_sio_oe,
  input  logic [3:0]  i_mem_sio
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_STREAM
  } state_t;

  localparam logic [7:0] SQI_CMD_READ = 8'h03;

  // Wide enough that the saturated count can always reach CS_IDLE_CYC.
  localparam int          CS_W       = $clog2(CS_IDLE_CYC + 1);
  localparam logic [CS_W-1:0] CS_HI_MAX = '1;

  state_t          state_q;
  logic [1:0]      ctr_q;
  logic [2:0]      sub_q;      // position within CMD / ADDR / DUMMY
  logic [CS_W-1:0] cs_hi_q;    // completed cycles with cs_n high
  logic [15:0]     target_q;   // word address the current fetch reads from
  logic [15:0]     pc_q;
  logic            cs_n_q;
  logic            sio_oe_q;
  logic [3:0]      sio_q;

  logic [1:0]      ctr_d;
  logic [CS_W-1:0] cs_hi_d;
  logic            cs_idle_met;
  logic            redirect_take;

  assign ctr_d         = ctr_q + 2'd1;
  assign cs_hi_d       = (cs_hi_q == CS_HI_MAX) ? cs_hi_q : cs_hi_q + 1'b1;
  // The current cycle also counts as cs-high time, hence the +1.
  assign cs_idle_met   = (int'(cs_hi_q) + 1) >= int'(CS_IDLE_CYC);
  assign redirect_take = i_ex_redirect && (ctr_q == 2'd3);

  // Nibble idx (0 = most significant) of the 24-bit byte address of a word.
  function automatic logic [3:0] addr_nib(input logic [15:0] pc,
                                          input logic [2:0]  idx);
    logic [23:0] byte_addr;
    byte_addr = {7'b0, pc, 1'b0};
    case (idx)
      3'd0:    addr_nib = byte_addr[23:20];
      3'd1:    addr_nib = byte_addr[19:16];
      3'd2:    addr_nib = byte_addr[15:12];
      3'd3:    addr_nib = byte_addr[11:8];
      3'd4:    addr_nib = byte_addr[7:4];
      3'd5:    addr_nib = byte_addr[3:0];
      default: addr_nib = 4'h0;
    endcase
  endfunction

  // Memory-side outputs are registered so that each value is set up one edge
  // ahead of the cycle in which the SRAM samples it. The transition into CMD
  // happens on the ctr==1 edge so that CMD occupies ctr 2,3.
  // NOTE: every state element here is assigned with <= so all reads in this
  // block see the pre-edge values regardless of statement order.
  always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
    if (!i_ex_rst_n) begin
      state_q  <= ST_IDLE;
      ctr_q    <= 2'd0;
      sub_q    <= 3'd0;
      cs_hi_q  <= '0;
      target_q <= RESET_PC;
      pc_q     <= RESET_PC;
      cs_n_q   <= 1'b1;
      sio_oe_q <= 1'b0;
      sio_q    <= 4'h0;
    end else begin
      ctr_q <= ctr_d;

      if (redirect_take) begin
        // Abort whatever is in flight; the current word (if any) was already
        // sampled by the execute stage on this edge.
        state_q  <= ST_IDLE;
        sub_q    <= 3'd0;
        cs_hi_q  <= (state_q == ST_IDLE) ? cs_hi_d : '0;
        target_q <= i_ex_redirect_pc;
        pc_q     <= i_ex_redirect_pc;
        cs_n_q   <= 1'b1;
        sio_oe_q <= 1'b0;
        sio_q    <= 4'h0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if ((ctr_q == 2'd1) && cs_idle_met) begin
              state_q  <= ST_CMD;
              sub_q    <= 3'd0;
              cs_hi_q  <= '0;
              cs_n_q   <= 1'b0;
              sio_oe_q <= 1'b1;
              sio_q    <= SQI_CMD_READ[7:4];
            end else begin
              cs_hi_q  <= cs_hi_d;
            end
          end

          ST_CMD: begin
            if (sub_q == 3'd0) begin
              sub_q <= 3'd1;
              sio_q <= SQI_CMD_READ[3:0];
            end else begin
              state_q <= ST_ADDR;
              sub_q   <= 3'd0;
              sio_q   <= addr_nib(target_q, 3'd0);
            end
          end

          ST_ADDR: begin
            if (sub_q != 3'd5) begin
              sub_q <= sub_q + 3'd1;
              sio_q <= addr_nib(target_q, sub_q + 3'd1);
            end else begin
              state_q  <= ST_DUMMY;
              sub_q    <= 3'd0;
              sio_oe_q <= 1'b0;
              sio_q    <= 4'h0;
            end
          end

          ST_DUMMY: begin
            if (sub_q == 3'd0) begin
              sub_q <= 3'd1;
            end else begin
              state_q <= ST_STREAM;
              sub_q   <= 3'd0;
            end
          end

          ST_STREAM: begin
            // The SRAM auto-increments, so only the reported PC advances.
            if (ctr_q == 2'd3) begin
              pc_q <= pc_q + 16'd1;
            end
          end

          default: begin
            state_q  <= ST_IDLE;
            sub_q    <= 3'd0;
            cs_n_q   <= 1'b1;
            sio_oe_q <= 1'b0;
            sio_q    <= 4'h0;
          end
        endcase
      end
    end
  end

  assign o_ex_ctr     = ctr_q;
  assign o_ex_pc      = pc_q;
  assign o_ex_enc_vld = (state_q == ST_STREAM);
  assign o_ex_enc     = (state_q == ST_STREAM) ? i_mem_sio : 4'h0;
  assign o_mem_cs_n   = cs_n_q;
  assign o_mem_sio    = sio_q;
  assign o_mem_sio_oe = sio_oe_q;

endmodule
